// File: rtl/des_key_sched.sv
// DES / 3DES round-subkey generator: streams the 16 PC-2 subkeys of each stage key
// over a valid/ready handshake, reloading C/D at stage boundaries without a bubble.
module des_key_sched #(
    parameter int NUM_KEYS = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [64*NUM_KEYS-1:0]  key_in,
    input  logic                    decrypt_in,
    input  logic                    start_in,
    output logic                    ready_out,
    output logic [47:0]             subkey_out,
    output logic                    subkey_valid_out,
    input  logic                    subkey_ready_in,
    output logic [3:0]              round_out,
    output logic [1:0]              key_sel_out,
    output logic                    done_out
);

    if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
        $error("des_key_sched: NUM_KEYS must be 1 or 3");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] PC1_TAB [56] = '{
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
        8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
        8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
        8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
        8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    localparam logic [7:0] PC2_TAB [48] = '{
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
        8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
        8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
        8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
        8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] v;
        v = '0;
        for (int i = 0; i < 56; i++) begin
            v[6'(55 - i)] = k[6'(8'd64 - PC1_TAB[6'(i)])];
        end
        return v;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 48; i++) begin
            v[6'(47 - i)] = cd[6'(8'd56 - PC2_TAB[6'(i)])];
        end
        return v;
    endfunction

    // Zero-based round index n uses a single-bit rotation in FIPS rounds 1, 2, 9 and 16.
    function automatic logic shiftIsOne(input logic [3:0] n);
        return (n == 4'd0) || (n == 4'd1) || (n == 4'd8) || (n == 4'd15);
    endfunction

    function automatic logic [27:0] rotate(input logic [27:0] x, input logic right, input logic one);
        logic [27:0] v;
        if (right) v = one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
        else       v = one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
        return v;
    endfunction

    // 3DES EDE runs E-D-E over keys 0,1,2; decrypting reverses both key order and each direction.
    function automatic logic [1:0] stageKey(input logic [1:0] stage, input logic dec);
        if (NUM_KEYS == 1) return 2'd0;
        return dec ? (2'd2 - stage) : stage;
    endfunction

    function automatic logic stageDec(input logic [1:0] stage, input logic dec);
        if (NUM_KEYS == 1) return dec;
        return dec ^ (stage == 2'd1);
    endfunction

    logic [1:0]            r_state;
    logic [64*NUM_KEYS-1:0] r_keys;
    logic                  r_decrypt;
    logic [27:0]           r_c;
    logic [27:0]           r_d;
    logic [3:0]            r_round;
    logic [1:0]            r_stage;
    logic [1:0]            r_key_sel;
    logic                  r_stage_dec;

    logic [63:0] w_in_keys  [4];
    logic [63:0] w_reg_keys [4];

    for (genvar g = 0; g < 4; g++) begin : g_keys
        if (g < NUM_KEYS) begin : g_used
            assign w_in_keys[g]  = key_in[64*g +: 64];
            assign w_reg_keys[g] = r_keys[64*g +: 64];
        end else begin : g_unused
            assign w_in_keys[g]  = '0;
            assign w_reg_keys[g] = '0;
        end
    end

    logic        w_accept;
    logic        w_hs;
    logic        w_stage_end;
    logic        w_last_stage;
    logic        w_load_en;
    logic [1:0]  w_load_stage;
    logic        w_load_mode;
    logic [1:0]  w_load_sel;
    logic        w_load_dec;
    logic [63:0] w_load_key;
    logic [55:0] w_load_cd;
    logic        w_step_one;
    logic [27:0] w_step_c;
    logic [27:0] w_step_d;

    assign w_accept     = start_in && ready_out;
    assign w_hs         = subkey_valid_out && subkey_ready_in;
    assign w_stage_end  = r_stage_dec ? (r_round == 4'd0) : (r_round == 4'd15);
    assign w_last_stage = (r_stage == 2'(NUM_KEYS - 1));
    assign w_load_en    = w_accept || (w_hs && w_stage_end && !w_last_stage);

    // A new job takes its first key straight from key_in; later stages use the latched copy.
    always_comb begin
        w_load_stage = w_accept ? 2'd0 : (r_stage + 2'd1);
        w_load_mode  = w_accept ? decrypt_in : r_decrypt;
        w_load_sel   = stageKey(w_load_stage, w_load_mode);
        w_load_dec   = stageDec(w_load_stage, w_load_mode);
        w_load_key   = w_accept ? w_in_keys[w_load_sel] : w_reg_keys[w_load_sel];
        w_load_cd    = pc1(w_load_key);
        if (!w_load_dec) begin
            w_load_cd = {rotate(w_load_cd[55:28], 1'b0, 1'b1), rotate(w_load_cd[27:0], 1'b0, 1'b1)};
        end
    end

    // Decrypt undoes the rotation that produced the current round; encrypt applies the next one.
    assign w_step_one = shiftIsOne(r_stage_dec ? r_round : (r_round + 4'd1));
    assign w_step_c   = rotate(r_c, r_stage_dec, w_step_one);
    assign w_step_d   = rotate(r_d, r_stage_dec, w_step_one);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_IDLE;
            r_keys      <= '0;
            r_decrypt   <= 1'b0;
            r_c         <= '0;
            r_d         <= '0;
            r_round     <= '0;
            r_stage     <= '0;
            r_key_sel   <= '0;
            r_stage_dec <= 1'b0;
        end else begin
            if (w_accept) begin
                r_keys    <= key_in;
                r_decrypt <= decrypt_in;
            end

            if (w_load_en) begin
                r_stage     <= w_load_stage;
                r_key_sel   <= w_load_sel;
                r_stage_dec <= w_load_dec;
                r_round     <= w_load_dec ? 4'd15 : 4'd0;
                r_c         <= w_load_cd[55:28];
                r_d         <= w_load_cd[27:0];
            end else if (w_hs && !w_stage_end) begin
                r_round <= r_stage_dec ? (r_round - 4'd1) : (r_round + 4'd1);
                r_c     <= w_step_c;
                r_d     <= w_step_d;
            end

            case (r_state)
                ST_IDLE: if (start_in) r_state <= ST_RUN;
                ST_RUN:  if (w_hs && w_stage_end && w_last_stage) r_state <= ST_DONE;
                ST_DONE: r_state <= start_in ? ST_RUN : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready_out        = (r_state != ST_RUN);
    assign subkey_valid_out = (r_state == ST_RUN);
    assign done_out         = (r_state == ST_DONE);
    assign subkey_out       = subkey_valid_out ? pc2({r_c, r_d}) : 48'd0;
    assign round_out        = r_round;
    assign key_sel_out      = r_key_sel;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched: single-DES and 3DES instances checked against a
// queue of subkeys produced by an independent cumulative-rotation key-schedule model.
module tb_des_key_sched;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY_C  = 64'hA1B2C3D4E5F60718;
    localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

    int pc1Tab [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int pc2Tab [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int shiftTab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic         clk = 1'b0;
    logic         rstN = 1'b1;
    logic         startIn = 1'b0;
    logic         decryptIn = 1'b0;
    logic         subkeyReady = 1'b1;
    logic [191:0] keyIn = '0;
    logic         useTriple = 1'b0;

    logic         start1, start3;
    logic         ready1, valid1, done1, ready3, valid3, done3;
    logic [47:0]  subkey1, subkey3;
    logic [3:0]   round1, round3;
    logic [1:0]   keySel1, keySel3;

    logic         obsReady, obsValid, obsDone;
    logic [47:0]  obsSubkey;
    logic [3:0]   obsRound;
    logic [1:0]   obsKeySel;

    logic [53:0]  expQ [$];
    int           testsRun = 0;
    int           testsFailed = 0;

    assign start1    = startIn && !useTriple;
    assign start3    = startIn && useTriple;
    assign obsReady  = useTriple ? ready3  : ready1;
    assign obsValid  = useTriple ? valid3  : valid1;
    assign obsDone   = useTriple ? done3   : done1;
    assign obsSubkey = useTriple ? subkey3 : subkey1;
    assign obsRound  = useTriple ? round3  : round1;
    assign obsKeySel = useTriple ? keySel3 : keySel1;

    des_key_sched #(.NUM_KEYS(1)) dutSingle (
        .clk_in(clk), .rst_n_in(rstN), .key_in(keyIn[63:0]), .decrypt_in(decryptIn),
        .start_in(start1), .ready_out(ready1), .subkey_out(subkey1),
        .subkey_valid_out(valid1), .subkey_ready_in(subkeyReady), .round_out(round1),
        .key_sel_out(keySel1), .done_out(done1)
    );

    des_key_sched #(.NUM_KEYS(3)) dutTriple (
        .clk_in(clk), .rst_n_in(rstN), .key_in(keyIn), .decrypt_in(decryptIn),
        .start_in(start3), .ready_out(ready3), .subkey_out(subkey3),
        .subkey_valid_out(valid3), .subkey_ready_in(subkeyReady), .round_out(round3),
        .key_sel_out(keySel3), .done_out(done3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [47:0] refSubkey(input logic [63:0] key, input int r);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - pc1Tab[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n <= r; n++) begin
            for (int s = 0; s < shiftTab[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - pc2Tab[i])];
        return k;
    endfunction

    task automatic pushStage(input logic [63:0] key, input logic [1:0] sel, input bit dec);
        for (int j = 0; j < 16; j++) begin
            int r;
            r = dec ? 15 - j : j;
            expQ.push_back({sel, 4'(r), refSubkey(key, r)});
        end
    endtask

    task automatic pushJob(input logic [191:0] keys, input bit triple, input bit dec);
        if (!triple) begin
            pushStage(keys[63:0], 2'd0, dec);
        end else if (!dec) begin
            pushStage(keys[63:0], 2'd0, 1'b0);
            pushStage(keys[127:64], 2'd1, 1'b1);
            pushStage(keys[191:128], 2'd2, 1'b0);
        end else begin
            pushStage(keys[191:128], 2'd2, 1'b1);
            pushStage(keys[127:64], 2'd1, 1'b0);
            pushStage(keys[63:0], 2'd0, 1'b1);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " subkey"}, 64'(obsSubkey), 64'd0);
        checkOutput({tag, " valid"},  64'(obsValid),  64'd0);
        checkOutput({tag, " round"},  64'(obsRound),  64'd0);
        checkOutput({tag, " keysel"}, 64'(obsKeySel), 64'd0);
        checkOutput({tag, " done"},   64'(obsDone),   64'd0);
        checkOutput({tag, " ready"},  64'(obsReady),  64'd1);
    endtask

    // Called at posedge+1 with the block idle or done; returns at posedge+1 of the first RUN cycle.
    task automatic applyStimulus(input logic [191:0] keys, input bit dec, input bit holdStart);
        checkOutput("ready before start", 64'(obsReady), 64'd1);
        keyIn = keys;
        decryptIn = dec;
        startIn = 1'b1;
        subkeyReady = 1'b1;
        @(posedge clk);
        #1;
        if (!holdStart) startIn = 1'b0;
    endtask

    task automatic drainJob(input string tag, input int maxCycles, input int stallRound,
                            input int stallLen, input bit scramble, output int validCycles,
                            output int doneCycle, output logic [47:0] firstKey,
                            output logic [47:0] lastKey);
        int          stallLeft;
        bit          stalled;
        bit          finished;
        bit          gotFirst;
        logic [47:0] heldKey;
        logic [3:0]  heldRound;
        logic [53:0] exp;
        validCycles = 0;
        doneCycle = 0;
        firstKey = '0;
        lastKey = '0;
        stallLeft = stallLen;
        stalled = 0;
        finished = 0;
        gotFirst = 0;
        heldKey = '0;
        heldRound = '0;
        for (int cyc = 1; cyc <= maxCycles && !finished; cyc++) begin
            if (obsDone) begin
                doneCycle = cyc;
                finished = 1;
                checkOutput({tag, " queue drained"}, 64'(expQ.size()), 64'd0);
            end else if (obsValid) begin
                validCycles++;
                if (stalled) begin
                    checkOutput({tag, " stall subkey"}, 64'(obsSubkey), 64'(heldKey));
                    checkOutput({tag, " stall round"}, 64'(obsRound), 64'(heldRound));
                end
                if (int'(obsRound) == stallRound && stallLeft > 0) begin
                    subkeyReady = 1'b0;
                    stallLeft--;
                    heldKey = obsSubkey;
                    heldRound = obsRound;
                    stalled = 1;
                end else begin
                    subkeyReady = 1'b1;
                    stalled = 0;
                    if (expQ.size() == 0) begin
                        checkOutput({tag, " unexpected subkey"}, 64'(obsSubkey), 64'd0);
                    end else begin
                        exp = expQ.pop_front();
                        checkOutput({tag, " subkey"}, 64'(obsSubkey), 64'(exp[47:0]));
                        checkOutput({tag, " round"},  64'(obsRound),  64'(exp[51:48]));
                        checkOutput({tag, " keysel"}, 64'(obsKeySel), 64'(exp[53:52]));
                        if (!gotFirst) firstKey = obsSubkey;
                        gotFirst = 1;
                        lastKey = obsSubkey;
                    end
                end
            end
            if (scramble) begin
                keyIn = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                decryptIn = 1'($urandom_range(0, 1));
            end
            if (!finished) begin
                @(posedge clk);
                #1;
            end
        end
        if (!finished) checkOutput({tag, " done timeout"}, 64'd0, 64'd1);
        subkeyReady = 1'b1;
    endtask

    initial begin
        int          validCycles;
        int          doneCycle;
        int          sawValid;
        int          waited;
        logic [47:0] firstKey;
        logic [47:0] lastKey;

        #1 rstN = 1'b0;
        #1;
        checkResetOutputs("reset single");
        useTriple = 1'b1;
        #1;
        checkResetOutputs("reset triple");
        useTriple = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
        @(posedge clk);
        #1;

        sawValid = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid1 || valid3 || done1 || done3) sawValid++;
        end
        checkOutput("idle no valid", 64'(sawValid), 64'd0);
        checkOutput("idle ready", 64'(ready1 && ready3), 64'd1);

        $display("[TB] single DES encrypt with key changes after accept");
        pushJob({128'd0, KEY_A}, 1'b0, 1'b0);
        applyStimulus({128'd0, KEY_A}, 1'b0, 1'b0);
        drainJob("enc", 30, -1, 0, 1'b1, validCycles, doneCycle, firstKey, lastKey);
        checkOutput("enc valid cycles", 64'(validCycles), 64'd16);
        checkOutput("enc done cycle", 64'(doneCycle), 64'd17);
        checkOutput("enc first K1", 64'(firstKey), 64'(K1_A));
        checkOutput("enc last K16", 64'(lastKey), 64'(K16_A));
        @(posedge clk);
        #1;
        checkOutput("done one cycle", 64'(obsDone), 64'd0);
        checkOutput("back to idle valid", 64'(obsValid), 64'd0);

        $display("[TB] single DES decrypt");
        pushJob({128'd0, KEY_A}, 1'b0, 1'b1);
        applyStimulus({128'd0, KEY_A}, 1'b1, 1'b0);
        drainJob("dec", 30, -1, 0, 1'b0, validCycles, doneCycle, firstKey, lastKey);
        checkOutput("dec first K16", 64'(firstKey), 64'(K16_A));
        checkOutput("dec last K1", 64'(lastKey), 64'(K1_A));
        checkOutput("dec done cycle", 64'(doneCycle), 64'd17);

        $display("[TB] backpressure at round 5");
        pushJob({128'd0, KEY_A}, 1'b0, 1'b0);
        applyStimulus({128'd0, KEY_A}, 1'b0, 1'b0);
        drainJob("stall", 40, 5, 3, 1'b0, validCycles, doneCycle, firstKey, lastKey);
        checkOutput("stall valid cycles", 64'(validCycles), 64'd19);

        $display("[TB] 3DES encrypt, start held high");
        useTriple = 1'b1;
        pushJob({KEY_A, KEY_A, KEY_A}, 1'b1, 1'b0);
        applyStimulus({KEY_A, KEY_A, KEY_A}, 1'b0, 1'b1);
        drainJob("tde", 70, -1, 0, 1'b0, validCycles, doneCycle, firstKey, lastKey);
        checkOutput("tde valid cycles", 64'(validCycles), 64'd48);
        checkOutput("tde done", 64'(obsDone), 64'd1);
        @(posedge clk);
        #1;
        startIn = 1'b0;
        checkOutput("tde restart valid", 64'(obsValid), 64'd1);
        checkOutput("tde restart subkey", 64'(obsSubkey), 64'(K1_A));
        checkOutput("tde restart keysel", 64'(obsKeySel), 64'd0);
        #2 rstN = 1'b0;
        #1;
        checkResetOutputs("tde abort");
        #3 rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] 3DES decrypt, distinct keys");
        pushJob({KEY_C, KEY_B, KEY_A}, 1'b1, 1'b1);
        applyStimulus({KEY_C, KEY_B, KEY_A}, 1'b1, 1'b0);
        drainJob("tdd", 70, -1, 0, 1'b1, validCycles, doneCycle, firstKey, lastKey);
        checkOutput("tdd done cycle", 64'(doneCycle), 64'd49);

        $display("[TB] reset mid-job");
        useTriple = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus({128'd0, KEY_A}, 1'b0, 1'b0);
        waited = 0;
        while (obsRound != 4'd7 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("reach round 7", 64'(obsRound), 64'd7);
        #2 rstN = 1'b0;
        #1;
        checkResetOutputs("midjob reset");
        @(posedge clk);
        #1;
        checkOutput("midjob held done", 64'(obsDone), 64'd0);
        #3 rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post reset done", 64'(obsDone), 64'd0);
        checkOutput("post reset valid", 64'(obsValid), 64'd0);
        pushJob({128'd0, KEY_A}, 1'b0, 1'b0);
        applyStimulus({128'd0, KEY_A}, 1'b0, 1'b0);
        drainJob("post", 30, -1, 0, 1'b0, validCycles, doneCycle, firstKey, lastKey);
        checkOutput("post first K1", 64'(firstKey), 64'(K1_A));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 Parameter NUM_KEYS, default 1, number of 64-bit DES keys per job; SHALL be 1 (single DES) or 3 (3DES EDE), and any other value SHALL be an elaboration error.
REQ-002 clk_in  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 key_in  input  64*NUM_KEYS  key k occupies [64k+63:64k]; bit 64k+63 is FIPS 46-3 bit 1; parity bits are ignored.
REQ-005 decrypt_in  input  1  0 = encrypt subkey order, 1 = decrypt subkey order; sampled on start acceptance.
REQ-006 start_in  input  1  job request.
REQ-007 ready_out  output  1  1 = idle, and start_in will be accepted.
REQ-008 subkey_out  output  48  PC-2 round subkey; bit 47 is PC-2 output bit 1.
REQ-009 subkey_valid_out  output  1  subkey_out, round_out and key_sel_out are valid.
REQ-010 subkey_ready_in  input  1  consumer accepts the current subkey.
REQ-011 round_out  output  4  FIPS round number minus 1 (0..15) of the current subkey.
REQ-012 key_sel_out  output  2  key index (0..NUM_KEYS-1) of the current subkey.
REQ-013 done_out  output  1  one-cycle pulse when the last subkey of a job is accepted.

Function
REQ-014 The block SHALL have the states IDLE, RUN and DONE; ready_out SHALL be 1 in IDLE and DONE.
REQ-015 Accept is start_in=1 and ready_out=1 at a clock edge; at accept the block SHALL latch decrypt_in and all keys, and SHALL load C/D (2x28 bits) with PC-1 of the first stage key, pre-shifted for the first round; state SHALL go to RUN.
REQ-016 In RUN, subkey_valid_out SHALL be 1 and subkey_out SHALL equal PC-2(C,D); the first valid subkey SHALL appear the cycle after accept.
REQ-017 A handshake is subkey_valid_out=1 and subkey_ready_in=1; only a handshake SHALL advance round_out, C/D or the stage.
REQ-018 While subkey_ready_in=0, all outputs SHALL hold stable.
REQ-019 Stage encrypt direction: left rotations of 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rounds 1..16, with subkeys emitted in the order K1..K16 and round_out counting 0..15.
REQ-020 Stage decrypt direction: the first subkey SHALL be K16 (C/D = PC-1, no shift), followed by right rotations of 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 giving K15..K1, with round_out counting 15 down to 0.
REQ-021 For NUM_KEYS=1, the job SHALL be one stage using key 0 in the direction set by decrypt_in.
REQ-022 For NUM_KEYS=3 with decrypt_in=0, the stages SHALL be key0 encrypt, key1 decrypt, key2 encrypt.
REQ-023 For NUM_KEYS=3 with decrypt_in=1, the stages SHALL be key2 decrypt, key1 encrypt, key0 decrypt.
REQ-024 At a stage boundary, C/D SHALL be reloaded from the next key with no bubble cycle; each job SHALL yield exactly 16*NUM_KEYS subkeys.
REQ-025 The handshake on the last subkey SHALL move the state to DONE; in DONE, done_out=1, subkey_valid_out=0 and the block SHALL stay one cycle before going to IDLE, unless start_in=1, which SHALL be accepted as in REQ-015.
REQ-026 start_in while in RUN SHALL be ignored, and the running job SHALL be unaffected.
REQ-027 key_in and decrypt_in changes after accept SHALL have no effect on the running job.

Reset
REQ-028 rst_n_in=0 SHALL immediately force state to IDLE and C/D, the latched keys and the latched mode to 0.
REQ-029 Output values while in reset: subkey_out=0, subkey_valid_out=0, round_out=0, key_sel_out=0, done_out=0, ready_out=1.
REQ-030 A reset mid-job SHALL abort the job with no done_out pulse; the first edge after release SHALL be able to accept a new start.

Verification
REQ-031 Reset then idle: all outputs at REQ-029 values; ready_out=1; no valid asserted for 20 cycles with start_in=0.
REQ-032 NUM_KEYS=1, key 133457799BBCDFF1, encrypt, ready held 1: 16 consecutive valid cycles; first subkey 1B02EFFC7072 (round 0), last CB3D8B0E17F5 (round 15); done_out on the 17th cycle.
REQ-033 Same key, decrypt: first subkey CB3D8B0E17F5 with round_out=15, last 1B02EFFC7072 with round_out=0; all 16 subkeys match a reference model in reverse order.
REQ-034 Backpressure: subkey_ready_in=0 for 3 cycles at round 5 -> subkey_out/round_out stable during the stall; job completes in 19 valid cycles with the subkey sequence unchanged.
REQ-035 NUM_KEYS=3, all keys 133457799BBCDFF1, encrypt -> 48 subkeys: key_sel 0 K1..K16, key_sel 1 K16..K1, key_sel 2 K1..K16; start_in held high through the job is ignored until DONE, then accepted.
REQ-036 Reset asserted at round 7 -> outputs zero asynchronously, no done_out; after release a new encrypt job produces 1B02EFFC7072 first.
